// File: rtl/rgmii_idelay_tuner.sv
// RGMII RX IDELAY calibration: sweeps a shared tap, scores FCS results per tap,
// and loads the centre of the longest contiguous passing window.
module rgmii_idelay_tuner #(
  parameter int NUM_LANES      = 5,
  parameter int TAP_WIDTH      = 5,
  parameter int TAP_MAX        = 31,
  parameter int DEFAULT_TAP    = 0,
  parameter int FRAMES_PER_TAP = 16,
  parameter int SETTLE_CYCLES  = 64,
  parameter int TIMEOUT_CYCLES = 1250000
) (
  input  logic                 clk_int,
  input  logic                 rst_int,
  input  logic                 start,
  input  logic                 rx_frame_valid,
  input  logic                 rx_frame_good,
  output logic [TAP_WIDTH-1:0] delay_value,
  output logic [NUM_LANES-1:0] delay_ld,
  output logic                 busy,
  output logic                 done,
  output logic                 locked,
  output logic [TAP_WIDTH-1:0] best_tap,
  output logic [TAP_WIDTH:0]   window_len
);

  localparam int CMAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ?
                        TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int FW = $clog2(FRAMES_PER_TAP + 1);
  localparam int LW = TAP_WIDTH + 1;

  localparam logic [CW-1:0]        SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]        TO_LAST     = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0]        FPT         = FW'(FRAMES_PER_TAP);
  localparam logic [TAP_WIDTH-1:0] TMAX        = TAP_WIDTH'(TAP_MAX);
  localparam logic [TAP_WIDTH-1:0] DEF         = TAP_WIDTH'(DEFAULT_TAP);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETTLE, COUNT, EVAL, APPLY, DONE
  } state_t;

  state_t               state_q;
  logic [TAP_WIDTH-1:0] tap_q;
  logic [CW-1:0]        cnt_q;
  logic [FW-1:0]        seen_q, good_q;
  logic [LW-1:0]        cur_len_q, best_len_q;
  logic [TAP_WIDTH-1:0] cur_start_q, best_start_q;
  logic [TAP_WIDTH-1:0] dv_q, best_tap_q;
  logic [NUM_LANES-1:0] ld_q;
  logic                 busy_q, done_q, locked_q;
  logic [LW-1:0]        wlen_q;

  logic [FW-1:0]        seen_d, good_d;
  logic [LW-1:0]        cur_len_d;
  logic [TAP_WIDTH-1:0] centre_d;
  logic                 pass;

  always_comb begin
    seen_d    = seen_q + FW'(rx_frame_valid);
    good_d    = good_q + FW'(rx_frame_valid & rx_frame_good);
    pass      = (good_q == FPT);
    cur_len_d = pass ? cur_len_q + LW'(1) : '0;
    centre_d  = best_start_q +
                TAP_WIDTH'((best_len_q - LW'(1)) >> 1);
  end

  always_ff @(posedge clk_int) begin
    if (rst_int) begin
      state_q      <= IDLE;
      tap_q        <= '0;
      cnt_q        <= '0;
      seen_q       <= '0;
      good_q       <= '0;
      cur_len_q    <= '0;
      best_len_q   <= '0;
      cur_start_q  <= '0;
      best_start_q <= '0;
      dv_q         <= DEF;
      best_tap_q   <= DEF;
      ld_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      locked_q     <= 1'b0;
      wlen_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          ld_q <= '0;
          if (start) begin
            tap_q        <= '0;
            cur_len_q    <= '0;
            best_len_q   <= '0;
            cur_start_q  <= '0;
            best_start_q <= '0;
            done_q       <= 1'b0;
            locked_q     <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= LOAD;
          end
        end
        LOAD: begin
          dv_q    <= tap_q;
          ld_q    <= '1;
          cnt_q   <= '0;
          state_q <= SETTLE;
        end
        SETTLE: begin
          ld_q <= '0;
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            seen_q  <= '0;
            good_q  <= '0;
            state_q <= COUNT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        COUNT: begin
          // a frame landing on the timeout cycle is still scored
          seen_q <= seen_d;
          good_q <= good_d;
          cnt_q  <= cnt_q + CW'(1);
          if (seen_d == FPT || cnt_q == TO_LAST)
            state_q <= EVAL;
        end
        EVAL: begin
          cur_len_q <= cur_len_d;
          if (!pass)
            cur_start_q <= tap_q + TAP_WIDTH'(1);
          if (pass && cur_len_d > best_len_q) begin
            best_len_q   <= cur_len_d;
            best_start_q <= cur_start_q;
          end
          if (tap_q == TMAX) begin
            state_q <= APPLY;
          end else begin
            tap_q   <= tap_q + TAP_WIDTH'(1);
            state_q <= LOAD;
          end
        end
        APPLY: begin
          if (best_len_q == '0) begin
            best_tap_q <= DEF;
            dv_q       <= DEF;
            locked_q   <= 1'b0;
          end else begin
            best_tap_q <= centre_d;
            dv_q       <= centre_d;
            locked_q   <= 1'b1;
          end
          ld_q    <= '1;
          wlen_q  <= best_len_q;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign delay_value = dv_q;
  assign delay_ld    = ld_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign locked      = locked_q;
  assign best_tap    = best_tap_q;
  assign window_len  = wlen_q;

endmodule

// File: tb/tb_rgmii_idelay_tuner.sv
// Randomised bench for rgmii_idelay_tuner against a brute-force
// window-search model of the tap sweep.
module tb_rgmii_idelay_tuner;

  localparam int NL  = 5;
  localparam int TW  = 5;
  localparam int NT  = 32;
  localparam int DEF = 3;
  localparam int FPT = 4;
  localparam int ST  = 8;
  localparam int TO  = 40;
  localparam int BND = ST + TO + 3 * FPT + 40;

  logic          clk = 1'b0;
  logic          rst_int, start, rx_v, rx_g;
  logic [TW-1:0] delay_value, best_tap;
  logic [NL-1:0] delay_ld;
  logic          busy, done, locked;
  logic [TW:0]   window_len;

  int checks = 0;
  int errors = 0;
  int ld_cnt = 0;
  int exp_best = DEF;
  int exp_len = 0;
  int cyc = 0;

  rgmii_idelay_tuner #(
    .NUM_LANES(NL), .TAP_WIDTH(TW), .TAP_MAX(NT - 1),
    .DEFAULT_TAP(DEF), .FRAMES_PER_TAP(FPT),
    .SETTLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_int(clk), .rst_int(rst_int), .start(start),
    .rx_frame_valid(rx_v), .rx_frame_good(rx_g),
    .delay_value(delay_value), .delay_ld(delay_ld),
    .busy(busy), .done(done), .locked(locked),
    .best_tap(best_tap), .window_len(window_len)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // longest all-ones run; scanning long-to-short, left-to-right
  function automatic void model(input logic [31:0] m,
                                output int len, output int st);
    logic [31:0] w;
    len = 0;
    st  = 0;
    for (int l = NT; l >= 1; l--) begin
      for (int s = 0; s + l <= NT; s++) begin
        w = (l == 32) ? 32'hffff_ffff : ((32'h1 << l) - 1);
        if (len == 0 && ((m >> s) & w) == w) begin
          len = l;
          st  = s;
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_int) begin
      chk("busy_done_excl", busy & done, 0);
      if (delay_ld != '0) begin
        chk("ld_uniform", delay_ld, {NL{1'b1}});
        if (ld_cnt < NT)
          chk("ld_tap", delay_value, ld_cnt);
        else if (ld_cnt == NT) begin
          chk("ld_apply", delay_value, exp_best);
          chk("ld_apply_done", done, 1);
        end else
          chk("ld_extra", ld_cnt, NT);
        ld_cnt++;
      end
      if (done && !busy) begin
        chk("res_best", best_tap, exp_best);
        chk("res_len", window_len, exp_len);
        chk("res_lock", locked, exp_len > 0);
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_dv"}, delay_value, DEF);
    chk({tag, "_ld"}, delay_ld, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_lock"}, locked, 0);
    chk({tag, "_best"}, best_tap, DEF);
    chk({tag, "_len"}, window_len, 0);
  endtask

  task automatic frame(input logic g);
    tick();
    rx_v = 1'b1;
    rx_g = g;
    tick();
    rx_v = 1'b0;
    rx_g = 1'($urandom_range(0, 1));
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic wait_ld(output bit found);
    found = 1'b0;
    for (int i = 0; i < BND && !found; i++) begin
      @(negedge clk);
      if (delay_ld != '0) found = 1'b1;
    end
    if (!found) chk("ld_wait_timeout", 0, 1);
  endtask

  task automatic run_sweep(input logic [31:0] mask,
                           input bit bad_settle,
                           input bit no_frames,
                           input int restart_tap,
                           input int abort_tap,
                           input bit chk_iv,
                           input int lit_len,
                           input int lit_best,
                           input int lit_lock);
    int len, st, t_prev, b, n;
    bit found;
    model(mask, len, st);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_len  = len;
    exp_best = (len > 0) ? st + (len - 1) / 2 : DEF;
    ld_cnt   = 0;
    t_prev   = 0;
    for (int k = 0; k < NT; k++) begin
      wait_ld(found);
      if (!found) return;
      if (chk_iv && k > 0)
        chk("tap_interval", cyc - t_prev, ST + TO + 2);
      t_prev = cyc;
      if (k == abort_tap) begin
        tick();
        rst_int = 1'b1;
        tick();
        rst_int = 1'b0;
        @(negedge clk);
        chk_reset("abort");
        exp_len  = 0;
        exp_best = DEF;
        return;
      end
      for (int j = 1; j <= ST; j++) begin
        tick();
        rx_v  = bad_settle && j <= ST - 2;
        rx_g  = 1'b0;
        start = (k == restart_tap) && j == 2;
      end
      rx_v  = 1'b0;
      start = 1'b0;
      if (no_frames) begin
      end else if (mask[k]) begin
        for (int i = 0; i < FPT; i++) frame(1'b1);
      end else if ($urandom_range(0, 1) == 0) begin
        b = $urandom_range(0, FPT - 1);
        for (int i = 0; i < FPT; i++) frame(i != b);
      end else begin
        n = $urandom_range(0, FPT - 1);
        for (int i = 0; i < n; i++) frame(1'b1);
      end
    end
    found = 1'b0;
    for (int i = 0; i < BND && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    chk("done_seen", found, 1);
    repeat (3) tick();
    @(negedge clk);
    chk("ld_total", ld_cnt, NT + 1);
    chk("busy_end", busy, 0);
    if (lit_len >= 0) begin
      chk("lit_len", window_len, lit_len);
      chk("lit_best", best_tap, lit_best);
      chk("lit_lock", locked, lit_lock);
    end
  endtask

  logic [31:0] m;

  initial begin
    rst_int = 1'b1;
    start   = 1'b0;
    rx_v    = 1'b0;
    rx_g    = 1'b0;
    repeat (3) tick();
    rst_int = 1'b0;
    @(negedge clk);
    chk_reset("reset");
    run_sweep(32'hffff_ffff, 0, 0, -1, -1, 0, 32, 15, 1);
    m = ((32'h1 << 21) - 1) & ~((32'h1 << 10) - 1);
    run_sweep(m, 0, 0, -1, -1, 0, 11, 15, 1);
    m = 32'h0000_0038 | 32'h0000_ff00 | 32'h0ff0_0000;
    run_sweep(m, 0, 0, -1, -1, 0, 8, 11, 1);
    run_sweep(32'h0, 0, 1, -1, -1, 1, 0, DEF, 0);
    run_sweep(32'hffff_ffff, 1, 0, -1, -1, 0, 32, 15, 1);
    for (int r = 0; r < 3; r++) begin
      m = $urandom | $urandom;
      run_sweep(m, 1'($urandom_range(0, 1)), 0, -1, -1, 0,
                -1, 0, 0);
    end
    m = $urandom | $urandom | $urandom;
    run_sweep(m, 0, 0, 5, -1, 0, -1, 0, 0);
    run_sweep(m, 0, 0, -1, 7, 0, -1, 0, 0);
    m = ((32'h1 << 21) - 1) & ~((32'h1 << 10) - 1);
    run_sweep(m, 0, 0, -1, -1, 0, 11, 15, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
